// File: rtl/rr_bus_arbiter8.sv
// Round-robin arbiter for an external 8:1 32-bit word mux: registered one-hot grant and select,
// valid/ready beat handshake to a single consumer, and a MAX_HOLD beat cap per contended tenure.
module rr_bus_arbiter8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       out_ready,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       bus_valid,
  output logic       beat,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e            state_q, state_d;
  logic [7:0]        grant_q, grant_d;
  logic [2:0]        sel_q, sel_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [CntW-1:0]   hold_q, hold_d;
  logic [CntW-1:0]   cnt_inc;

  logic [7:0]        arb_mask;
  logic              found;
  logic [2:0]        win;
  logic [2:0]        idx;
  logic              owner_req;
  logic              others;
  logic              cap_hit;
  logic              release_now;

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign busy      = (state_q == StGrant);
  assign bus_valid = |(grant_q & req);
  assign beat      = bus_valid & out_ready;

  // The current owner is excluded from the search, so a release always moves the path on.
  assign arb_mask = (state_q == StIdle) ? req : (req & ~grant_q);

  // Rotate-priority encoder: first set bit of arb_mask scanning ptr+1, ptr+2, ... mod 8.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 1; i <= 8; i++) begin
      idx = ptr_q + i[2:0];
      if (!found && arb_mask[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign owner_req   = |(req & grant_q);
  assign others      = |(req & ~grant_q);
  assign cnt_inc     = hold_q + 1'b1;
  assign cap_hit     = beat && (cnt_inc == CntW'(MAX_HOLD));
  assign release_now = !owner_req || (cap_hit && others);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          grant_d = 8'(1) << win;
          sel_d   = win;
          ptr_d   = win;
          hold_d  = '0;
        end
      end
      StGrant: begin
        // A lone owner reaching the cap simply wraps the count and keeps the path.
        if (beat) begin
          hold_d = cap_hit ? '0 : cnt_inc;
        end
        if (release_now) begin
          hold_d = '0;
          if (found) begin
            grant_d = 8'(1) << win;
            sel_d   = win;
            ptr_d   = win;
          end else begin
            grant_d = '0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= 3'd7;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter8.sv
// Scoreboard bench for rr_bus_arbiter8: directed steps push hand-computed expectations, and a
// negedge monitor pops and compares them against the DUT outputs.
module tb_rr_bus_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       out_ready;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       bus_valid;
  logic       beat;
  logic       busy;

  typedef struct {
    int         id;
    logic [7:0] g;
    logic [2:0] s;
    logic       b;
    logic       v;
    logic       bt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;
  int   step_id;

  rr_bus_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .bus_valid (bus_valid),
    .beat      (beat),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs just after a rising edge; expectation describes the registered state after that
  // edge, with bus_valid/beat derived from the expected grant and the newly applied inputs.
  task automatic step(input logic r, input logic [7:0] rq, input logic rdy,
                      input logic [7:0] eg, input logic [2:0] es, input logic eb);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    req       = rq;
    out_ready = rdy;
    e.id = step_id;
    e.g  = eg;
    e.s  = es;
    e.b  = eb;
    e.v  = |(eg & rq);
    e.bt = (|(eg & rq)) & rdy;
    exp_q.push_back(e);
    step_id++;
  endtask

  task automatic do_reset();
    step(1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (grant !== e.g || sel !== e.s || busy !== e.b || bus_valid !== e.v || beat !== e.bt)
        begin
          n_bad++;
          $display("FAIL step%0d: got grant=%h sel=%0d busy=%b valid=%b beat=%b, want grant=%h sel=%0d busy=%b valid=%b beat=%b",
                   e.id, grant, sel, busy, bus_valid, beat, e.g, e.s, e.b, e.v, e.bt);
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0] rdy_seq;
    int wait_cnt;
    n_cmp     = 0;
    n_bad     = 0;
    step_id   = 0;
    rst       = 1'b1;
    req       = 8'h00;
    out_ready = 1'b1;

    // Lone requester: granted one cycle later, keeps the path across cap wraps.
    do_reset();
    step(1'b0, 8'h04, 1'b1, 8'h00, 3'd0, 1'b0);
    for (int k = 0; k < 11; k++) step(1'b0, 8'h04, 1'b1, 8'h04, 3'd2, 1'b1);

    // All requesting: MAX_HOLD beats each, rotating 0..7,0 with no gap.
    do_reset();
    step(1'b0, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0);
    for (int k = 0; k < 33; k++) begin
      step(1'b0, 8'hFF, 1'b1, 8'(1) << ((k / 4) % 8), 3'((k / 4) % 8), 1'b1);
    end

    // Owner 3 drops to idle; sel holds; next search starts at 4 and wraps to 0.
    do_reset();
    step(1'b0, 8'h08, 1'b1, 8'h00, 3'd0, 1'b0);
    step(1'b0, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h08, 3'd3, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h00, 3'd3, 1'b0);
    step(1'b0, 8'h01, 1'b1, 8'h00, 3'd3, 1'b0);
    step(1'b0, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1);

    // Stalls: cap counts accepted beats only (ready 1,0,0,1,1,0,1).
    do_reset();
    step(1'b0, 8'h20, 1'b1, 8'h00, 3'd0, 1'b0);
    rdy_seq = 8'b0101_1001;
    for (int k = 0; k < 7; k++) step(1'b0, 8'h21, rdy_seq[k], 8'h20, 3'd5, 1'b1);
    step(1'b0, 8'h21, 1'b1, 8'h01, 3'd0, 1'b1);

    // Asynchronous reset mid-tenure (sel=6, hold=2), then pointer restarts at source 0.
    do_reset();
    step(1'b0, 8'h40, 1'b1, 8'h00, 3'd0, 1'b0);
    step(1'b0, 8'h40, 1'b1, 8'h40, 3'd6, 1'b1);
    step(1'b0, 8'h40, 1'b1, 8'h40, 3'd6, 1'b1);
    step(1'b1, 8'h41, 1'b1, 8'h00, 3'd0, 1'b0);
    step(1'b0, 8'h41, 1'b1, 8'h00, 3'd0, 1'b0);
    step(1'b0, 8'h41, 1'b1, 8'h01, 3'd0, 1'b1);

    // Owner 2 drops as 7 raises: direct handover without an idle cycle.
    do_reset();
    step(1'b0, 8'h04, 1'b1, 8'h00, 3'd0, 1'b0);
    step(1'b0, 8'h04, 1'b1, 8'h04, 3'd2, 1'b1);
    step(1'b0, 8'h80, 1'b1, 8'h04, 3'd2, 1'b1);
    step(1'b0, 8'h80, 1'b1, 8'h80, 3'd7, 1'b1);
    step(1'b0, 8'h80, 1'b1, 8'h80, 3'd7, 1'b1);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
